button_conditioner: RTL and testbench

//  Input-conditioning stage directly upstream of the traffic top. Conditions raw

---
 rtl/button_conditioner_if.sv | 27 ++
 rtl/button_conditioner.sv | 138 +++++++++++++
 tb/tb_button_conditioner.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw button inputs in, conditioned levels and pulses out.
// The board/top side uses master, the conditioner uses slave.
interface button_conditioner_if #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] btn_raw;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;
  logic             press_any;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  press_any
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output press_any
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel 2-FF synchronizer plus counter debounce with registered press/release pulses.
// Optional hold-to-repeat press pulses are enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner #(
  parameter int WIDTH     = 9,
  parameter int DB_CYCLES = 50000,
  parameter int RPT_DELAY = 25000000,
  parameter int RPT_RATE  = 5000000
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  localparam int              CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  generate
    if (DB_CYCLES < 2 || RPT_DELAY < 1 || RPT_RATE < 1) begin : g_bad_params
      $error("button_conditioner: DB_CYCLES must be >= 2, RPT_DELAY and RPT_RATE >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] press_q;
  logic [WIDTH-1:0] release_q;
  logic             press_any_q;
  logic [CW-1:0]    cnt_q [WIDTH];

  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rpt;
  logic [WIDTH-1:0] press_d;

  // A change is accepted only after DB_CYCLES consecutive disagreeing samples;
  // any agreeing sample throws away the partial count.
  always_comb begin
    level_d = level_q;
    accept  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s2[i];
          accept[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise    = accept & s2;
  assign fall    = accept & ~s2;
  assign press_d = rise | rpt;

`ifdef BTN_AUTOREPEAT_EN
  localparam int            HMAX       = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int            HW         = $clog2(HMAX + 1);
  localparam logic [HW-1:0] DELAY_LAST = HW'(RPT_DELAY - 1);
  localparam logic [HW-1:0] RATE_LAST  = HW'(RPT_RATE - 1);

  logic [HW-1:0]    hc_q [WIDTH];
  logic [HW-1:0]    hc_d [WIDTH];
  logic [WIDTH-1:0] rep_q;
  logic [WIDTH-1:0] rep_d;

  // rep_q marks that the first (long) delay has elapsed, so later pulses use the short rate.
  // A release in the same cycle wins, so a repeat never lands on btn_release.
  always_comb begin
    rpt   = '0;
    rep_d = rep_q;
    for (int i = 0; i < WIDTH; i++) begin
      hc_d[i] = hc_q[i];
      if (!level_q[i] || fall[i]) begin
        hc_d[i]  = '0;
        rep_d[i] = 1'b0;
      end else if (hc_q[i] == (rep_q[i] ? RATE_LAST : DELAY_LAST)) begin
        rpt[i]   = 1'b1;
        hc_d[i]  = '0;
        rep_d[i] = 1'b1;
      end else begin
        hc_d[i] = hc_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        hc_q[i] <= '0;
      end
    end else begin
      rep_q <= rep_d;
      for (int i = 0; i < WIDTH; i++) begin
        hc_q[i] <= hc_d[i];
      end
    end
  end
`else
  assign rpt = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      press_any_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1          <= bus.btn_raw;
      s2          <= s1;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= fall;
      press_any_q <= |press_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.press_any   = press_any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a window-based reference model predicts
// levels and pulse events; a negedge monitor compares them against the DUT.
module tb_button_conditioner;

  localparam int WIDTH = 9;
  localparam int DB    = 4;
  localparam int RD    = 10;
  localparam int RR    = 3;

  typedef struct {
    int               edge_no;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] rel;
  } event_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  button_conditioner_if #(.WIDTH(WIDTH)) bus ();

  button_conditioner #(
    .WIDTH    (WIDTH),
    .DB_CYCLES(DB),
    .RPT_DELAY(RD),
    .RPT_RATE (RR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int edge_no     = 0;
  int press0_cnt  = 0;

  event_t           sb_q [$];
  logic [WIDTH-1:0] hist [$];
  logic [WIDTH-1:0] m_level = '0;
  int               last_flip [WIDTH];
  int               accept_at [WIDTH];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] v, input int n);
    bus.btn_raw = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic syncEdge();
    @(posedge clk);
    #2;
  endtask

  // Waits (bounded) for a press or release pulse on one channel and checks its edge offset.
  task automatic waitFor(input int ch, input bit rel, input int start, input int lat, input string name);
    int got;
    got = -1;
    for (int k = 0; k < 40 && got < 0; k++) begin
      @(negedge clk);
      if ((rel ? bus.btn_release[ch] : bus.btn_press[ch]) === 1'b1) got = edge_no - start;
    end
    checkOutput(name, got, lat);
  endtask

  // Reference model: a level flips once the synchronised input (raw delayed two edges)
  // has disagreed with it for DB whole cycles, counted only since the last flip or reset.
  always @(posedge clk) begin : model
    logic [WIDTH-1:0] pr, rl, smp, nxt;
    bit               ok;
    int               d;
    if (hist.size() == 0) hist.push_back('0);
    edge_no++;
    if (rst) begin
      hist.push_back('0);
      m_level = '0;
      for (int ch = 0; ch < WIDTH; ch++) last_flip[ch] = edge_no;
    end else begin
      hist.push_back(bus.btn_raw);
      pr  = '0;
      rl  = '0;
      nxt = m_level;
      for (int ch = 0; ch < WIDTH; ch++) begin
        ok = (edge_no - last_flip[ch] >= DB);
        for (int k = edge_no - DB - 1; k <= edge_no - 2; k++) begin
          if (k < 0) ok = 0;
          else begin
            smp = hist[k];
            if (smp[ch] === m_level[ch]) ok = 0;
          end
        end
        if (ok) begin
          nxt[ch]       = ~m_level[ch];
          last_flip[ch] = edge_no;
          if (nxt[ch]) begin
            pr[ch]        = 1'b1;
            accept_at[ch] = edge_no;
          end else begin
            rl[ch] = 1'b1;
          end
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (m_level[ch]) begin
          d = edge_no - accept_at[ch];
          if (d == RD || (d > RD && (d - RD) % RR == 0)) pr[ch] = 1'b1;
        end
`endif
      end
      m_level = nxt;
      if ((pr | rl) != '0) sb_q.push_back('{edge_no: edge_no, press: pr, rel: rl});
    end
  end

  always @(negedge clk) begin : monitor
    event_t ev;
    checkOutput("level", 32'(bus.btn_level), 32'(m_level));
    while (sb_q.size() > 0 && sb_q[0].edge_no < edge_no) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL missed_pulse: got no pulse, expected press %0h release %0h at edge %0d",
               sb_q[0].press, sb_q[0].rel, sb_q[0].edge_no);
      void'(sb_q.pop_front());
    end
    if (bus.btn_press !== '0 || bus.btn_release !== '0 || bus.press_any !== 1'b0) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_pulse: got press %0h release %0h any %0b, expected none (edge %0d)",
                 bus.btn_press, bus.btn_release, bus.press_any, edge_no);
      end else begin
        ev = sb_q.pop_front();
        checkOutput("pulse_edge", 32'(edge_no), 32'(ev.edge_no));
        checkOutput("press", 32'(bus.btn_press), 32'(ev.press));
        checkOutput("release", 32'(bus.btn_release), 32'(ev.rel));
        checkOutput("press_any", 32'(bus.press_any), 32'(|ev.press));
      end
    end
    if (bus.btn_press[0] === 1'b1) press0_cnt++;
  end

  initial begin
    logic [WIDTH-1:0] v;
    int               start;
    int               p0;
    bus.btn_raw = '0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_level", 32'(bus.btn_level), 32'd0);
    checkOutput("reset_press", 32'(bus.btn_press), 32'd0);
    checkOutput("reset_release", 32'(bus.btn_release), 32'd0);
    checkOutput("reset_press_any", 32'(bus.press_any), 32'd0);

    // Clean press on the clock-set button
    syncEdge();
    start       = edge_no;
    bus.btn_raw = 9'h001;
    waitFor(0, 1'b0, start, 6, "t1_press_latency");
    syncEdge();
    applyStimulus('0, 12);

    // Short bursts never get through
    for (int r = 0; r < 5; r++) begin
      applyStimulus(9'h008, 3);
      applyStimulus('0, 3);
    end
    applyStimulus('0, 8);
    @(negedge clk);
    checkOutput("t2_glitch_level3", 32'(bus.btn_level[3]), 32'd0);
    syncEdge();

    // Release latency
    applyStimulus(9'h020, 10);
    start       = edge_no;
    bus.btn_raw = '0;
    waitFor(5, 1'b1, start, 6, "t3_release_latency");
    syncEdge();
    applyStimulus('0, 4);

    // Simultaneous presses
    applyStimulus(9'h102, 10);
    applyStimulus('0, 10);

    // Reset mid-debounce while another channel is held high
    applyStimulus(9'h080, 8);
    bus.btn_raw = 9'h084;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_async_level", 32'(bus.btn_level), 32'd0);
    checkOutput("t5_async_press_any", 32'(bus.press_any), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    start = edge_no;
    waitFor(2, 1'b0, start, 6, "t5_press_after_reset");
    syncEdge();
    applyStimulus('0, 10);

    // Long hold
    p0 = press0_cnt;
    applyStimulus(9'h001, 30);
    applyStimulus('0, 12);
`ifdef BTN_AUTOREPEAT_EN
    checkOutput("t6_hold_press_count", 32'(press0_cnt - p0), 32'd8);
`else
    checkOutput("t6_hold_press_count", 32'(press0_cnt - p0), 32'd1);
`endif

    // Random mix of glitches, holds and multi-channel changes
    for (int n = 0; n < 250; n++) begin
      v = bus.btn_raw;
      case ($urandom_range(0, 3))
        0:       v = WIDTH'($urandom);
        1:       v = v ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        2:       v = '0;
        default: v = v | (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      endcase
      applyStimulus(v, int'($urandom_range(1, 9)));
    end
    applyStimulus('0, 20);

    @(negedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach its end, limit 200000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule
